// File: rtl/instruction_cache.sv
// Direct-mapped read-only instruction cache: same-cycle hits, 4-beat line refill on miss,
// and a whole-cache invalidate for fence.i that is deferred while a refill is in flight.
module instruction_cache #(
  parameter int INDEX_BITS = 6
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [29:0] core_address_i,
  output logic [29:0] core_instr_o,
  output logic        core_blocking_n_o,
  input  logic        flush_i,
  output logic        mem_req_o,
  output logic [27:0] mem_address_o,
  input  logic [31:0] mem_data_i,
  input  logic        mem_valid_i
);

  localparam int LINES = 1 << INDEX_BITS;
  localparam int TAG_W = 28 - INDEX_BITS;

  localparam logic [0:0] S_LOOKUP = 1'b0;
  localparam logic [0:0] S_REFILL = 1'b1;

  logic [0:0]       r_state;
  logic [LINES-1:0] r_valid;
  logic [1:0]       r_beat;
  logic             r_flushPending;
  logic [27:0]      r_refillAddr;

  logic [29:0]      r_data [LINES*4];
  logic [TAG_W-1:0] r_tag  [LINES];

  logic [1:0]            w_offset;
  logic [INDEX_BITS-1:0] w_index;
  logic [TAG_W-1:0]      w_tag;
  logic [INDEX_BITS-1:0] w_refillIndex;
  logic [TAG_W-1:0]      w_refillTag;
  logic                  w_hit;
  logic                  w_beatDone;
  logic                  w_lastBeat;
  logic [1:0]            w_unusedLowBits;

  assign w_offset        = core_address_i[1:0];
  assign w_index         = core_address_i[INDEX_BITS+1:2];
  assign w_tag           = core_address_i[29:INDEX_BITS+2];
  assign w_refillIndex   = r_refillAddr[INDEX_BITS-1:0];
  assign w_refillTag     = r_refillAddr[27:INDEX_BITS];
  assign w_unusedLowBits = mem_data_i[1:0];

  assign w_hit      = (r_state == S_LOOKUP) && r_valid[w_index] && (r_tag[w_index] == w_tag);
  assign w_beatDone = (r_state == S_REFILL) && mem_valid_i;
  assign w_lastBeat = w_beatDone && (r_beat == 2'd3);

  assign core_blocking_n_o = w_hit;
  assign core_instr_o      = w_hit ? r_data[{w_index, w_offset}] : 30'd0;
  assign mem_req_o         = (r_state == S_REFILL);
  assign mem_address_o     = r_refillAddr;

  // Control path; a flush seen during a refill is held until the burst ends so the
  // line being filled can never come out valid.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state        <= S_LOOKUP;
      r_valid        <= '0;
      r_beat         <= 2'd0;
      r_flushPending <= 1'b0;
      r_refillAddr   <= 28'd0;
    end else begin
      case (r_state)
        S_LOOKUP: begin
          if (flush_i) r_valid <= '0;
          if (!w_hit) begin
            r_refillAddr <= core_address_i[29:2];
            r_beat       <= 2'd0;
            r_state      <= S_REFILL;
          end
        end
        S_REFILL: begin
          if (flush_i) r_flushPending <= 1'b1;
          if (w_beatDone) r_beat <= r_beat + 2'd1;
          if (w_lastBeat) begin
            r_state        <= S_LOOKUP;
            r_flushPending <= 1'b0;
            if (r_flushPending || flush_i) r_valid <= '0;
            else                           r_valid[w_refillIndex] <= 1'b1;
          end
        end
        default: r_state <= S_LOOKUP;
      endcase
    end
  end

  // Data and tag storage carry no reset so they can map onto plain RAM.
  always_ff @(posedge clk_i) begin
    if (!rst_i && w_beatDone) r_data[{w_refillIndex, r_beat}] <= mem_data_i[31:2];
    if (!rst_i && w_lastBeat) r_tag[w_refillIndex] <= w_refillTag;
  end

endmodule

// File: tb/tb_instruction_cache.sv
// Directed bench for instruction_cache: a memory model supplies refill beats and a
// scoreboard queue holds the instruction words expected back on hits.
module tb_instruction_cache;

  logic        clk = 1'b0;
  logic        rst;
  logic [29:0] coreAddress;
  logic [29:0] coreInstr;
  logic        coreBlockingN;
  logic        flush;
  logic        memReq;
  logic [27:0] memAddress;
  logic [31:0] memData;
  logic        memValid;

  int testsRun  = 0;
  int testsFail = 0;
  logic [29:0] sbQ [$];

  instruction_cache #(.INDEX_BITS(6)) dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .core_address_i   (coreAddress),
    .core_instr_o     (coreInstr),
    .core_blocking_n_o(coreBlockingN),
    .flush_i          (flush),
    .mem_req_o        (memReq),
    .mem_address_o    (memAddress),
    .mem_data_i       (memData),
    .mem_valid_i      (memValid)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Instruction memory contents by word address; line 0x100 holds the canonical program.
  function automatic logic [31:0] memWord(input logic [29:0] wordAddr);
    case (wordAddr)
      30'h40:  return 32'h0000_0013;
      30'h41:  return 32'h0010_0093;
      30'h42:  return 32'h0020_0113;
      30'h43:  return 32'h0030_0193;
      default: return {wordAddr ^ 30'h15A5_A5A5, 2'b11};
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] observed, input logic [31:0] expected);
    testsRun++;
    assert (observed === expected) else begin
      testsFail++;
      $error("[TB] FAIL %s: observed %h expected %h", name, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [29:0] addr, input logic fl, input logic valid, input logic [31:0] data);
    coreAddress = addr;
    flush       = fl;
    memValid    = valid;
    memData     = data;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic fetchExpectHit(input logic [29:0] addr, input logic fl);
    logic [29:0] expWord;
    logic [31:0] full;
    full = memWord(addr);
    applyStimulus(addr, fl, 1'b0, 32'd0);
    sbQ.push_back(full[31:2]);
    @(negedge clk);
    checkOutput("hit_blocking_n", {31'd0, coreBlockingN}, 32'd1);
    checkOutput("hit_mem_req", {31'd0, memReq}, 32'd0);
    expWord = sbQ.pop_front();
    checkOutput("hit_instr", {2'b00, coreInstr}, {2'b00, expWord});
    nextCycle();
  endtask

  task automatic fetchExpectMiss(input logic [29:0] addr);
    applyStimulus(addr, 1'b0, 1'b0, 32'd0);
    @(negedge clk);
    checkOutput("miss_blocking_n", {31'd0, coreBlockingN}, 32'd0);
    checkOutput("miss_instr", {2'b00, coreInstr}, 32'd0);
    checkOutput("miss_mem_req", {31'd0, memReq}, 32'd0);
    nextCycle();
  endtask

  // Runs a burst from the cycle after the miss; optional idle gap before beat 2,
  // an address redirect during that gap, and a flush on a chosen beat.
  task automatic refillLine(input logic [27:0] line, input int gapLen, input bit redirect,
                            input logic [29:0] redirectAddr, input int flushBeat);
    for (int b = 0; b < 4; b++) begin
      if (b == 2) begin
        for (int g = 0; g < gapLen; g++) begin
          applyStimulus(redirect ? redirectAddr : coreAddress, 1'b0, 1'b0, 32'hDEAD_BEEF);
          @(negedge clk);
          checkOutput("gap_mem_req", {31'd0, memReq}, 32'd1);
          checkOutput("gap_mem_address", {4'd0, memAddress}, {4'd0, line});
          checkOutput("gap_blocking_n", {31'd0, coreBlockingN}, 32'd0);
          nextCycle();
        end
      end
      applyStimulus(coreAddress, (b == flushBeat), 1'b1, memWord({line, b[1:0]}));
      @(negedge clk);
      checkOutput("beat_mem_req", {31'd0, memReq}, 32'd1);
      checkOutput("beat_mem_address", {4'd0, memAddress}, {4'd0, line});
      checkOutput("beat_blocking_n", {31'd0, coreBlockingN}, 32'd0);
      nextCycle();
    end
    applyStimulus(coreAddress, 1'b0, 1'b0, 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    applyStimulus(30'h40, 1'b0, 1'b0, 32'd0);
    nextCycle();
    @(negedge clk);
    checkOutput("reset_mem_req", {31'd0, memReq}, 32'd0);
    checkOutput("reset_mem_address", {4'd0, memAddress}, 32'd0);
    checkOutput("reset_blocking_n", {31'd0, coreBlockingN}, 32'd0);
    checkOutput("reset_instr", {2'b00, coreInstr}, 32'd0);
    nextCycle();
    rst = 1'b0;

    // cold miss on 0x100, then the rest of the line
    fetchExpectMiss(30'h40);
    refillLine(28'h10, 0, 1'b0, 30'h0, -1);
    fetchExpectHit(30'h40, 1'b0);
    fetchExpectHit(30'h41, 1'b0);
    fetchExpectHit(30'h42, 1'b0);
    fetchExpectHit(30'h43, 1'b0);

    // conflict eviction: 0x500 shares the index of 0x100
    fetchExpectMiss(30'h140);
    refillLine(28'h50, 0, 1'b0, 30'h0, -1);
    fetchExpectHit(30'h140, 1'b0);
    fetchExpectHit(30'h143, 1'b0);
    fetchExpectMiss(30'h40);

    // gapped burst with redirect to 0x200; back-to-back miss follows
    refillLine(28'h10, 3, 1'b1, 30'h80, -1);
    fetchExpectMiss(30'h80);
    refillLine(28'h20, 0, 1'b0, 30'h0, -1);
    fetchExpectHit(30'h80, 1'b0);
    fetchExpectHit(30'h42, 1'b0);

    // flush in lookup: same-cycle hit uses old valid bits
    fetchExpectHit(30'h41, 1'b1);
    fetchExpectMiss(30'h40);

    // flush during beat 2 leaves the refilled line invalid
    refillLine(28'h10, 0, 1'b0, 30'h0, 2);
    fetchExpectMiss(30'h40);
    refillLine(28'h10, 0, 1'b0, 30'h0, -1);
    fetchExpectHit(30'h43, 1'b0);

    // flush on beat 3 also counts as pending and clears every line
    fetchExpectMiss(30'h80);
    refillLine(28'h20, 0, 1'b0, 30'h0, 3);
    fetchExpectMiss(30'h80);
    refillLine(28'h20, 0, 1'b0, 30'h0, -1);
    fetchExpectHit(30'h81, 1'b0);
    fetchExpectMiss(30'h40);

    // reset during beat 1 abandons the burst
    applyStimulus(30'h40, 1'b0, 1'b1, memWord(30'h40));
    nextCycle();
    rst = 1'b1;
    applyStimulus(30'h40, 1'b0, 1'b1, memWord(30'h41));
    nextCycle();
    rst = 1'b0;
    fetchExpectMiss(30'h40);
    refillLine(28'h10, 0, 1'b0, 30'h0, -1);
    fetchExpectHit(30'h40, 1'b0);
    fetchExpectHit(30'h41, 1'b0);
    fetchExpectHit(30'h43, 1'b0);
    fetchExpectMiss(30'h80);
    refillLine(28'h20, 0, 1'b0, 30'h0, -1);
    fetchExpectHit(30'h82, 1'b0);

    checkOutput("scoreboard_drained", sbQ.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFail);
    $finish;
  end

endmodule
